// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Sequencing FSM for the multi-cycle MIPS-subset CPU. It decodes the IR
// opcode/funct fields together with its current state and drives the datapath
// enables and multiplexer selects. It also waits on the memory-ready
// handshake, keeps a retired-instruction counter and flags illegal opcodes.
//
// Handshake: in FETCH, MEM_RD and MEM_WR the controller holds its memory
// strobe and address select steady. It advances only in the cycle where
// mem_ready=1; that same cycle is the transfer cycle. mem_ready is ignored in
// every other state.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   OpCode, Funct         IR[31:26] and IR[5:0], stable from DECODE to retire
//   mem_ready             memory finishes the current MemRead/MemWrite
//   PCWrite..PCSource     datapath enables and selects
//   state                 current state encoding (debug/observation)
//   retire                one-cycle pulse when an instruction completes
//   illegal               one-cycle pulse in DECODE for an unsupported opcode
//   instr_count           retired-instruction counter, wraps at all-ones
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUSel,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB_ALU = 4'd5,
        S_WB_MEM = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q;

    // Instruction classification from the IR fields
    logic is_rtype, is_lw, is_sw, is_beq, is_j, is_jal, is_jr, is_jalr;
    logic is_shift, is_itype, is_jump, supported;

    assign is_rtype  = (OpCode == 6'h00);
    assign is_lw     = (OpCode == 6'h23);
    assign is_sw     = (OpCode == 6'h2b);
    assign is_beq    = (OpCode == 6'h04);
    assign is_j      = (OpCode == 6'h02);
    assign is_jal    = (OpCode == 6'h03);
    assign is_jr     = is_rtype && (Funct == 6'd8);
    assign is_jalr   = is_rtype && (Funct == 6'd9);
    assign is_shift  = is_rtype && ((Funct == 6'd0) || (Funct == 6'd2) || (Funct == 6'd3));
    assign is_itype  = (OpCode == 6'h0f) || (OpCode == 6'h08) || (OpCode == 6'h09) ||
                       (OpCode == 6'h0c) || (OpCode == 6'h0a) || (OpCode == 6'h0b);
    assign is_jump   = is_j || is_jal || is_jr || is_jalr;
    assign supported = is_rtype || is_lw || is_sw || is_beq || is_j || is_jal || is_itype;

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUSel      = 2'b00;
        PCSource    = 2'b00;
        retire      = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every cycle; IR and PC load only on the transfer cycle
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here for BRANCH
                ALUSrcB = 2'b11;
                if (is_jump) begin
                    state_d = S_JUMP;
                end else if (is_beq) begin
                    state_d = S_BRANCH;
                end else if (!supported) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    ALUSel  = 2'b00;
                    state_d = is_lw ? S_MEM_RD : S_MEM_WR;
                end else begin
                    if (is_shift) begin
                        ALUSrcA = 2'b10;
                        ALUSrcB = 2'b00;
                    end else if (is_rtype) begin
                        ALUSrcA = 2'b01;
                        ALUSrcB = 2'b00;
                    end else begin
                        ALUSrcA = 2'b01;
                        ALUSrcB = 2'b10;
                    end
                    ALUSel  = 2'b10;
                    state_d = S_WB_ALU;
                end
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                RegDst   = is_rtype ? 2'b01 : 2'b00;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 2'b01;
                ALUSel      = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b11;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
                // R-type jumps (jr/jalr) take the target from register A
                PCSource = is_rtype ? 2'b10 : 2'b01;
                if (is_jal) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
                if (is_jalr) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b01;
                    MemtoReg = 2'b10;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Reset abandons the instruction: no strobe or pulse may escape
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 2'b00;
            MemtoReg    = 2'b00;
            ALUSrcA     = 2'b00;
            ALUSrcB     = 2'b00;
            ALUSel      = 2'b00;
            PCSource    = 2'b00;
            retire      = 1'b0;
            illegal     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule
